// File: rtl/seg7_dec_scan_if.sv
// Display-stage bus: incoming byte strobe plus the 7-segment drive and busy flag.
interface seg7_dec_scan_if;
    logic [8:1] bc;
    logic       bc_vld;
    logic [6:0] ss;
    logic [4:1] dig;
    logic       busy;

    modport master (
        output bc,
        output bc_vld,
        input  ss,
        input  dig,
        input  busy
    );

    modport slave (
        input  bc,
        input  bc_vld,
        output ss,
        output dig,
        output busy
    );
endinterface

// File: rtl/seg7_dec_scan.sv
// Byte -> 3-digit BCD (shift-add-3, one bit per clock) with a 4-digit active-low scan.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on hundreds/tens.
module seg7_dec_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic          CLK,
    input  logic          RST,
    seg7_dec_scan_if.slave bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [19:0] sr;
    logic [7:0]  pend;
    logic        pend_vld;
    logic        busy_r;

    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [6:0]    ss_r;
    logic [3:0]    dig_r;

    logic [6:0]  hund_seg;
    logic [6:0]  tens_seg;
    logic [6:0]  ones_seg;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift in the next bit.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Converter: IDLE loads, SHIFT runs 8 iterations, COMMIT updates the display atomically.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            sr       <= 20'd0;
            pend     <= 8'd0;
            pend_vld <= 1'b0;
            busy_r   <= 1'b0;
            hund     <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bc_vld || pend_vld) begin
                        sr       <= {12'd0, (bus.bc_vld ? bus.bc : pend)};
                        cnt      <= 3'd0;
                        pend_vld <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= dd_step(sr);
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hund   <= sr[19:16];
                    tens   <= sr[15:12];
                    ones   <= sr[11:8];
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // Strobes during a conversion park in the single pending slot; last one wins.
            if (bus.bc_vld && (state != IDLE)) begin
                pend     <= bus.bc;
                pend_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        hund_seg = seg_of(hund);
        tens_seg = seg_of(tens);
        ones_seg = seg_of(ones);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (hund == 4'd0) begin
            hund_seg = SEG_BLANK;
        end
        if ((hund == 4'd0) && (tens == 4'd0)) begin
            tens_seg = SEG_BLANK;
        end
`endif
    end

    // Scan: free-running prescaler; ss and dig come from the same edge so they always agree.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc <= '0;
            idx   <= 2'd0;
            ss_r  <= SEG_BLANK;
            dig_r <= 4'hF;
        end else begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end

            case (idx)
                2'd0: begin
                    dig_r <= 4'b1110;
                    ss_r  <= ones_seg;
                end
                2'd1: begin
                    dig_r <= 4'b1101;
                    ss_r  <= tens_seg;
                end
                2'd2: begin
                    dig_r <= 4'b1011;
                    ss_r  <= hund_seg;
                end
                default: begin
                    dig_r <= 4'b0111;
                    ss_r  <= SEG_BLANK;
                end
            endcase
        end
    end

    assign bus.ss   = ss_r;
    assign bus.dig  = dig_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_seg7_dec_scan.sv
// Self-checking bench for seg7_dec_scan against a cycle-count reference model of the display stage.
module tb_seg7_dec_scan;

    localparam int SD = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    seg7_dec_scan_if bus();

    seg7_dec_scan #(.SCAN_DIV(SD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] dseq [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int checks = 0;
    int errors = 0;

    // Reference model: decimal value on display, cycles since load, single pending slot.
    int         m_k;
    int         m_phase;
    int         m_conv;
    int         m_pend;
    int         m_disp;
    bit         m_pvld;
    logic [6:0] m_ss;
    logic [3:0] m_dig;
    logic       m_busy;

    logic [6:0] cap [0:3];

    function automatic logic [6:0] ref_seg(input int d, input int val);
        int h, t, o;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        case (d)
            0: return seg_tab[o];
            1: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (h == 0 && t == 0) return 7'h7F;
`endif
                return seg_tab[t];
            end
            2: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (h == 0) return 7'h7F;
`endif
                return seg_tab[h];
            end
            default: return 7'h7F;
        endcase
    endfunction

    task automatic tick(input logic r, input logic v, input logic [7:0] b);
        int d;
        RST        = r;
        bus.bc_vld = v;
        bus.bc     = b;
        @(posedge CLK);
        if (!r) begin
            m_k = 0; m_phase = 0; m_pend = 0; m_pvld = 0; m_disp = 0; m_conv = 0;
            m_ss = 7'h7F; m_dig = 4'hF; m_busy = 1'b0;
        end else begin
            d     = (m_k / SD) % 4;
            m_dig = dseq[d];
            m_ss  = ref_seg(d, m_disp);
            m_k++;
            if (m_phase == 0) begin
                if (v || m_pvld) begin
                    m_conv  = v ? int'(b) : m_pend;
                    m_pvld  = 0;
                    m_phase = 1;
                end
            end else begin
                if (v) begin
                    m_pend = int'(b);
                    m_pvld = 1;
                end
                if (m_phase == 9) begin
                    m_disp  = m_conv;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            m_busy = (m_phase != 0);
        end
        #1;
    endtask

    task automatic capture_frame();
        for (int i = 0; i < 4 * SD; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            case (bus.dig)
                4'b1110: cap[0] = bus.ss;
                4'b1101: cap[1] = bus.ss;
                4'b1011: cap[2] = bus.ss;
                4'b0111: cap[3] = bus.ss;
                default: cap[3] = 7'hxx;
            endcase
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 8'd0);
            checks++;
            if (bus.ss !== 7'h7F || bus.dig !== 4'hF || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset: ss=%h dig=%b busy=%b, want ss=7f dig=1111 busy=0",
                         bus.ss, bus.dig, bus.busy);
            end
        end
        for (int i = 0; i < 4 * SD; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            checks++;
            if (bus.dig !== dseq[i / SD]) begin
                errors++;
                $display("FAIL scan_order[%0d]: dig=%b want %b", i, bus.dig, dseq[i / SD]);
            end
            if (i < SD) begin
                checks++;
                if (bus.ss !== 7'h40) begin
                    errors++;
                    $display("FAIL reset_ones[%0d]: ss=%h want 40", i, bus.ss);
                end
            end
        end
    endtask

    task automatic test_255();
        for (int i = 0; i <= 10; i++) begin
            tick(1'b1, (i == 0), 8'd255);
            checks++;
            if (bus.busy !== (i < 9)) begin
                errors++;
                $display("FAIL busy255[N+%0d]: busy=%b want %b", i, bus.busy, (i < 9));
            end
        end
        capture_frame();
        checks++;
        if (cap[2] !== 7'h24 || cap[1] !== 7'h12 || cap[0] !== 7'h12 || cap[3] !== 7'h7F) begin
            errors++;
            $display("FAIL frame255: got %h %h %h %h want 7f 24 12 12",
                     cap[3], cap[2], cap[1], cap[0]);
        end
    endtask

    task automatic test_7();
        logic [6:0] lead;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = 7'h7F;
`else
        lead = 7'h40;
`endif
        for (int i = 0; i <= 10; i++) tick(1'b1, (i == 0), 8'd7);
        capture_frame();
        checks++;
        if (cap[2] !== lead || cap[1] !== lead || cap[0] !== 7'h78 || cap[3] !== 7'h7F) begin
            errors++;
            $display("FAIL frame7: got %h %h %h %h want 7f %h %h 78",
                     cap[3], cap[2], cap[1], cap[0], lead, lead);
        end
    endtask

    task automatic test_pending_overwrite();
        logic       v;
        logic [7:0] b;
        int         seen42;
        seen42 = 0;
        for (int i = 0; i <= 22; i++) begin
            v = (i == 0 || i == 3 || i == 5);
            b = (i == 0) ? 8'd100 : (i == 3) ? 8'd42 : 8'd199;
            tick(1'b1, v, b);
            checks++;
            if ({bus.ss, bus.dig, bus.busy} !== {m_ss, m_dig, m_busy}) begin
                errors++;
                $display("FAIL pend_model[N+%0d]: ss=%h dig=%b busy=%b want ss=%h dig=%b busy=%b",
                         i, bus.ss, bus.dig, bus.busy, m_ss, m_dig, m_busy);
            end
            if (i == 9 || i == 10 || i == 19) begin
                checks++;
                if (bus.busy !== (i == 10)) begin
                    errors++;
                    $display("FAIL pend_busy[N+%0d]: busy=%b want %b", i, bus.busy, (i == 10));
                end
            end
            if (bus.dig === 4'b1101 && bus.ss === 7'h19) seen42++;
        end
        checks++;
        if (seen42 != 0) begin
            errors++;
            $display("FAIL never42: tens=4 shown %0d times, want 0", seen42);
        end
        capture_frame();
        checks++;
        if (cap[2] !== 7'h79 || cap[1] !== 7'h10 || cap[0] !== 7'h10) begin
            errors++;
            $display("FAIL frame199: got %h %h %h want 79 10 10", cap[2], cap[1], cap[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] lead;
        int         seen1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = 7'h7F;
`else
        lead = 7'h40;
`endif
        seen1 = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, (i == 0), 8'd128);
        tick(1'b0, 1'b0, 8'd0);
        checks++;
        if (bus.busy !== 1'b0 || bus.ss !== 7'h7F || bus.dig !== 4'hF) begin
            errors++;
            $display("FAIL midreset: busy=%b ss=%h dig=%b want 0 7f 1111", bus.busy, bus.ss, bus.dig);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_busy[%0d]: busy=%b want 0", i, bus.busy);
            end
            if (bus.dig === 4'b1011 && bus.ss === 7'h79) seen1++;
        end
        checks++;
        if (seen1 != 0) begin
            errors++;
            $display("FAIL no128: hundreds=1 shown %0d times, want 0", seen1);
        end
        capture_frame();
        checks++;
        if (cap[2] !== lead || cap[1] !== lead || cap[0] !== 7'h40) begin
            errors++;
            $display("FAIL frame_after_reset: got %h %h %h want %h %h 40",
                     cap[2], cap[1], cap[0], lead, lead);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] lead;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = 7'h7F;
`else
        lead = 7'h40;
`endif
        for (int i = 0; i <= 20; i++) begin
            tick(1'b1, (i <= 1), (i == 0) ? 8'd9 : 8'd90);
            checks++;
            if (bus.busy !== !(i == 9 || i >= 19)) begin
                errors++;
                $display("FAIL b2b_busy[N+%0d]: busy=%b want %b", i, bus.busy, !(i == 9 || i >= 19));
            end
            if (i == 11) begin
                checks++;
                if (m_disp != 9) begin
                    errors++;
                    $display("FAIL b2b_first: model shows %0d want 9", m_disp);
                end
            end
        end
        capture_frame();
        checks++;
        if (cap[2] !== lead || cap[1] !== 7'h10 || cap[0] !== 7'h40) begin
            errors++;
            $display("FAIL frame90: got %h %h %h want %h 10 40", cap[2], cap[1], cap[0], lead);
        end
    endtask

    task automatic test_random();
        logic       r, v;
        logic [7:0] b;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 5) == 0);
            b = 8'($urandom_range(0, 255));
            tick(r, v, b);
            checks++;
            if ({bus.ss, bus.dig, bus.busy} !== {m_ss, m_dig, m_busy}) begin
                errors++;
                if (errors < 30)
                    $display("FAIL random[%0d]: ss=%h dig=%b busy=%b want ss=%h dig=%b busy=%b",
                             i, bus.ss, bus.dig, bus.busy, m_ss, m_dig, m_busy);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            checks++;
            if ({bus.ss, bus.dig, bus.busy} !== {m_ss, m_dig, m_busy}) begin
                errors++;
                if (errors < 30)
                    $display("FAIL drain[%0d]: ss=%h dig=%b busy=%b want ss=%h dig=%b busy=%b",
                             i, bus.ss, bus.dig, bus.busy, m_ss, m_dig, m_busy);
            end
        end
    endtask

    initial begin
        bus.bc     = 8'd0;
        bus.bc_vld = 1'b0;
        test_reset();
        test_255();
        test_7();
        test_pending_overwrite();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
